// File: rtl/counter_pkg.sv
// Shared types and defaults for the modulo up/down counter family.
package counter_pkg;

    // Behaviour at the count boundary: wrap modulo MAX_VAL+1 or pin at the limit.
    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } cnt_mode_e;

    localparam int CNT_WIDTH_DEF  = 8;
    localparam int CNT_STEP_W_DEF = 4;

endpackage

// File: rtl/count_next_calc.sv
// Next-count arithmetic: adds or subtracts step in WIDTH+1 bits, detects the
// boundary crossing and applies the wrap or saturate rule.
module count_next_calc
    import counter_pkg::*;
#(
    parameter int              WIDTH   = CNT_WIDTH_DEF,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter int              STEP_W  = CNT_STEP_W_DEF,
    parameter cnt_mode_e       MODE    = CNT_WRAP
)(
    input  logic [WIDTH-1:0]  count,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  next_count,
    output logic              boundary,
    output logic              dir_up
);

    localparam int             XW    = WIDTH + 1;
    localparam logic [XW-1:0]  MAX_X = XW'(MAX_VAL);
    localparam logic [XW-1:0]  MOD_X = MAX_X + XW'(1'b1);

    logic [XW-1:0] count_x_s;
    logic [XW-1:0] step_x_s;
    logic [XW-1:0] sum_s;
    logic [XW-1:0] raw_s;
    logic          boundary_s;
    logic [XW-1:0] clamped_s;

    assign count_x_s = XW'(count);
    assign step_x_s  = XW'(step);
    assign sum_s     = count_x_s + step_x_s;

    // Direction-dependent step with boundary detection and wrap/saturate handling.
    always_comb begin
        raw_s      = count_x_s;
        boundary_s = 1'b0;
        if (up_down) begin
            if (sum_s > MAX_X) begin
                boundary_s = 1'b1;
                if (MODE == CNT_WRAP) begin
                    raw_s = sum_s - MOD_X;
                end else begin
                    raw_s = MAX_X;
                end
            end else begin
                raw_s = sum_s;
            end
        end else begin
            if (step_x_s > count_x_s) begin
                boundary_s = 1'b1;
                if (MODE == CNT_WRAP) begin
                    raw_s = count_x_s + MOD_X - step_x_s;
                end else begin
                    raw_s = {XW{1'b0}};
                end
            end else begin
                raw_s = count_x_s - step_x_s;
            end
        end
    end

    // Keep the result in range even for an out-of-range step.
    always_comb begin
        if (raw_s > MAX_X) begin
            clamped_s = MAX_X;
        end else begin
            clamped_s = raw_s;
        end
    end

    assign next_count = clamped_s[WIDTH-1:0];
    assign boundary   = boundary_s;
    assign dir_up     = up_down;

endmodule

// File: rtl/modn_updown_counter_chk.sv
// Simulation checks for the modulo counter: legal step and in-range count.
module modn_updown_counter_chk #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter int              STEP_W  = 4
)(
    input logic              clk,
    input logic              rst,
    input logic              clear,
    input logic              load,
    input logic              enable,
    input logic [STEP_W-1:0] step,
    input logic [WIDTH-1:0]  count
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    // A counting cycle must never request a step larger than the top count.
    a_step_legal: assert property (@(posedge clk) disable iff (rst)
        (enable && !clear && !load) |-> (WIDTH'(step) <= MAX_C));

    // The count never leaves 0..MAX_VAL.
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        (count <= MAX_C));

endmodule

// File: rtl/modn_updown_counter.sv
// Parametrised modulo up/down counter with variable step, wrap or saturate
// mode, terminal-count pulse, min/max flags and sticky overflow/underflow.
module modn_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH     = CNT_WIDTH_DEF,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter int              STEP_W    = CNT_STEP_W_DEF,
    parameter cnt_mode_e       MODE      = CNT_WRAP,
    parameter longint unsigned RESET_VAL = 64'd0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              enable,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;
    logic             unf_r;

    logic [WIDTH-1:0] calc_count_s;
    logic             calc_boundary_s;
    logic             calc_dir_up_s;

    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_nxt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;

    count_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W),
        .MODE    (MODE)
    ) u_calc (
        .count      (count_r),
        .up_down    (up_down),
        .step       (step),
        .next_count (calc_count_s),
        .boundary   (calc_boundary_s),
        .dir_up     (calc_dir_up_s)
    );

    // Priority mux: clear > load > counting step > hold.
    always_comb begin
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        ovf_nxt_s   = ovf_r;
        unf_nxt_s   = unf_r;
        if (clear) begin
            count_nxt_s = RESET_C;
            ovf_nxt_s   = 1'b0;
            unf_nxt_s   = 1'b0;
        end else if (load) begin
            if (d_in > MAX_C) begin
                count_nxt_s = MAX_C;
            end else begin
                count_nxt_s = d_in;
            end
        end else if (enable && (step != {STEP_W{1'b0}})) begin
            count_nxt_s = calc_count_s;
            tc_nxt_s    = calc_boundary_s;
            if (calc_boundary_s && calc_dir_up_s) begin
                ovf_nxt_s = 1'b1;
            end else if (calc_boundary_s) begin
                unf_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State registers with asynchronous reset to the programmed reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= RESET_C;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    assign count  = count_r;
    assign tc     = tc_r;
    assign ovf    = ovf_r;
    assign unf    = unf_r;
    assign at_max = (count_r == MAX_C);
    assign at_min = (count_r == {WIDTH{1'b0}});

    modn_updown_counter_chk #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .load   (load),
        .enable (enable),
        .step   (step),
        .count  (count_r)
    );

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: a mod-10 wrap instance, a mod-10 saturate
// instance and a default 8-bit instance, checked by vector table, directed
// sequences and a randomized run against an integer reference model.
module tb_modn_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0, load = 1'b0, enable = 1'b0, up_down = 1'b1;
    logic [3:0] d_in = 4'd0, step = 4'd0, step8 = 4'd0;
    logic [7:0] d_in8 = 8'd0;

    logic [3:0] cnt_w, cnt_s;
    logic [7:0] cnt_d;
    logic tc_w, tc_s, tc_d, mx_w, mx_s, mx_d, mn_w, mn_s, mn_d;
    logic ov_w, ov_s, ov_d, un_w, un_s, un_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    modn_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP_W(4), .MODE(CNT_WRAP), .RESET_VAL(0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .d_in(d_in), .enable(enable),
        .up_down(up_down), .step(step), .count(cnt_w), .tc(tc_w), .at_max(mx_w),
        .at_min(mn_w), .ovf(ov_w), .unf(un_w));

    modn_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP_W(4), .MODE(CNT_SATURATE), .RESET_VAL(0)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .d_in(d_in), .enable(enable),
        .up_down(up_down), .step(step), .count(cnt_s), .tc(tc_s), .at_max(mx_s),
        .at_min(mn_s), .ovf(ov_s), .unf(un_s));

    modn_updown_counter dut_d (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .d_in(d_in8), .enable(enable),
        .up_down(up_down), .step(step8), .count(cnt_d), .tc(tc_d), .at_max(mx_d),
        .at_min(mn_d), .ovf(ov_d), .unf(un_d));

    typedef struct {
        bit clr; bit ld; int d; bit en; bit up; int st;
        int e_cnt; bit e_tc; bit e_ovf; bit e_unf;
    } vec_t;

    vec_t vecs[$];

    // Reference state per instance: 0 = wrap mod 10, 1 = saturate mod 10, 2 = default 8-bit wrap.
    int m_cnt[3], m_tc[3], m_ovf[3], m_unf[3];
    int m_max[3] = '{9, 9, 255};
    bit m_sat[3] = '{1'b0, 1'b1, 1'b0};

    function automatic vec_t mk(bit clr, bit ld, int d, bit en, bit up, int st,
                                int e_cnt, bit e_tc, bit e_ovf, bit e_unf);
        vec_t v;
        v.clr = clr; v.ld = ld; v.d = d; v.en = en; v.up = up; v.st = st;
        v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level behaviour of one clock edge, in plain integer arithmetic.
    task automatic model_step(input int i, input bit clr, input bit ld, input int d,
                              input bit en, input bit up, input int st);
        int t;
        m_tc[i] = 0;
        if (clr) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end else if (ld) begin
            m_cnt[i] = (d > m_max[i]) ? m_max[i] : d;
        end else if (en && st != 0) begin
            t = up ? m_cnt[i] + st : m_cnt[i] - st;
            if (t > m_max[i]) begin
                m_tc[i] = 1; m_ovf[i] = 1;
                m_cnt[i] = m_sat[i] ? m_max[i] : t - (m_max[i] + 1);
            end else if (t < 0) begin
                m_tc[i] = 1; m_unf[i] = 1;
                m_cnt[i] = m_sat[i] ? 0 : t + (m_max[i] + 1);
            end else begin
                m_cnt[i] = t;
            end
        end
    endtask

    task automatic chk_inst(input int i);
        string nm;
        int c, t, o, u, mx, mn;
        case (i)
            0: begin nm = "wrap"; c = cnt_w; t = tc_w; o = ov_w; u = un_w; mx = mx_w; mn = mn_w; end
            1: begin nm = "sat";  c = cnt_s; t = tc_s; o = ov_s; u = un_s; mx = mx_s; mn = mn_s; end
            default: begin nm = "def"; c = cnt_d; t = tc_d; o = ov_d; u = un_d; mx = mx_d; mn = mn_d; end
        endcase
        chk({nm, "_count"}, c, m_cnt[i]);
        chk({nm, "_tc"}, t, m_tc[i]);
        chk({nm, "_ovf"}, o, m_ovf[i]);
        chk({nm, "_unf"}, u, m_unf[i]);
        chk({nm, "_at_max"}, mx, int'(m_cnt[i] == m_max[i]));
        chk({nm, "_at_min"}, mn, int'(m_cnt[i] == 0));
    endtask

    initial begin
        // clr ld d en up st | count tc ovf unf   (mod-10 wrap instance)
        vecs.push_back(mk(0, 1,  7, 0, 1, 0,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1,  8, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1,  9, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 1,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  1, 0, 0, 3,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 3,  8, 1, 1, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 3,  5, 0, 1, 1));
        vecs.push_back(mk(0, 1, 12, 0, 1, 0,  9, 0, 1, 1));
        vecs.push_back(mk(1, 1,  4, 0, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1,  4, 1, 1, 3,  4, 0, 0, 0));
        vecs.push_back(mk(0, 1,  5, 0, 1, 0,  5, 0, 0, 0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 0, 1, 3, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 5,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 9,  9, 0, 0, 0));

        // Reset state, before any clock edge.
        #3;
        chk("rst_count", cnt_w, 0);
        chk("rst_tc", tc_w, 0);
        chk("rst_ovf", ov_w, 0);
        chk("rst_at_min", mn_w, 1);
        #9 rst = 1'b0;

        foreach (vecs[k]) begin
            clear = vecs[k].clr; load = vecs[k].ld; d_in = 4'(vecs[k].d);
            enable = vecs[k].en; up_down = vecs[k].up; step = 4'(vecs[k].st);
            tick();
            chk($sformatf("vec%0d_count", k), cnt_w, vecs[k].e_cnt);
            chk($sformatf("vec%0d_tc", k), tc_w, vecs[k].e_tc);
            chk($sformatf("vec%0d_ovf", k), ov_w, vecs[k].e_ovf);
            chk($sformatf("vec%0d_unf", k), un_w, vecs[k].e_unf);
            chk($sformatf("vec%0d_at_max", k), mx_w, int'(vecs[k].e_cnt == 9));
            chk($sformatf("vec%0d_at_min", k), mn_w, int'(vecs[k].e_cnt == 0));
        end
        clear = 1'b0;

        // Asynchronous reset in mid-cycle with count=6 and ovf set.
        load = 1'b1; d_in = 4'd9; enable = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1; up_down = 1'b1; step = 4'd7;
        tick();
        chk("pre_rst_count", cnt_w, 6);
        chk("pre_rst_tc", tc_w, 1);
        chk("pre_rst_ovf", ov_w, 1);
        enable = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", cnt_w, 0);
        chk("async_rst_tc", tc_w, 0);
        chk("async_rst_ovf", ov_w, 0);
        chk("async_rst_unf", un_w, 0);
        chk("async_rst_at_min", mn_w, 1);
        #1 rst = 1'b0;

        // Saturate: pinned at the top keeps pulsing tc; exact landing at 0 does not.
        load = 1'b1; d_in = 4'd8;
        tick();
        chk("sat_load_count", cnt_s, 8);
        load = 1'b0; enable = 1'b1; up_down = 1'b1; step = 4'd3;
        tick();
        chk("sat_up_count", cnt_s, 9);
        chk("sat_up_tc", tc_s, 1);
        chk("sat_up_ovf", ov_s, 1);
        chk("sat_up_at_max", mx_s, 1);
        tick();
        chk("sat_pin_count", cnt_s, 9);
        chk("sat_pin_tc", tc_s, 1);
        up_down = 1'b0; step = 4'd9;
        tick();
        chk("sat_land_count", cnt_s, 0);
        chk("sat_land_tc", tc_s, 0);
        chk("sat_land_at_min", mn_s, 1);

        // Default 8-bit instance wraps 250 + 10 to 4.
        enable = 1'b0; load = 1'b1; d_in8 = 8'd250;
        tick();
        chk("def_load_count", cnt_d, 250);
        load = 1'b0; enable = 1'b1; up_down = 1'b1; step = 4'd1; step8 = 4'd10;
        tick();
        chk("def_wrap_count", cnt_d, 4);
        chk("def_wrap_tc", tc_d, 1);
        chk("def_wrap_ovf", ov_d, 1);

        // Randomized run against the reference model, starting from a clear.
        clear = 1'b1; load = 1'b0; enable = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            clear   = ($urandom_range(0, 31) == 0);
            load    = ($urandom_range(0, 7) == 0);
            enable  = ($urandom_range(0, 3) != 0);
            up_down = $urandom_range(0, 1) == 1;
            step    = 4'($urandom_range(0, 9));
            step8   = 4'($urandom_range(0, 15));
            d_in    = 4'($urandom_range(0, 15));
            d_in8   = 8'($urandom_range(0, 255));
            model_step(0, clear, load, int'(d_in), enable, up_down, int'(step));
            model_step(1, clear, load, int'(d_in), enable, up_down, int'(step));
            model_step(2, clear, load, int'(d_in8), enable, up_down, int'(step8));
            tick();
            for (int i = 0; i < 3; i++) chk_inst(i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised up/down counter with programmable modulus, variable step, and selectable wrap or saturate mode. It generalises the 4-bit up/down counter with load and enable in the lab counter family. It adds terminal-count pulses, min/max flags and sticky overflow/underflow status. Intended as the reusable timer/index building block for later lab blocks (decade counters, FIFO pointers, PWM).

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, highest legal count; modulus = MAX_VAL+1; must be < 2**WIDTH and ≥ 1
STEP_W, 4, width of step input; STEP_W ≤ WIDTH
MODE, CNT_WRAP, counter_pkg::cnt_mode_e: CNT_WRAP or CNT_SATURATE
RESET_VAL, 0, value on reset/clear; must be ≤ MAX_VAL

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear to RESET_VAL
load  in  1  synchronous load of d_in
d_in  in  WIDTH  load value
enable  in  1  count enable
up_down  in  1  1 = up, 0 = down
step  in  STEP_W  increment/decrement amount per enabled cycle
count  out  WIDTH  registered count
tc  out  1  registered one-cycle terminal-count pulse
at_max  out  1  combinational: count == MAX_VAL
at_min  out  1  combinational: count == 0
ovf  out  1  sticky: an up-boundary event has occurred
unf  out  1  sticky: a down-boundary event has occurred

Behaviour:
- rst=1 (asynchronous, no clock needed): count=RESET_VAL, tc=0, ovf=0, unf=0. Registers update on the first clk edge after rst falls.
- Per-edge priority is clear > load > enable > hold.
- clear: count=RESET_VAL, tc=0, ovf=0, unf=0.
- load: count = min(d_in, MAX_VAL); tc=0; ovf/unf unchanged.
- enable=0, or step=0: count holds, tc=0.
- Up count, no boundary: if count+step ≤ MAX_VAL, count += step.
- Up boundary event: if count+step > MAX_VAL:
  - CNT_WRAP: count = count+step-(MAX_VAL+1).
  - CNT_SATURATE: count = MAX_VAL.
  - Both modes: tc=1 next cycle, ovf set.
- Down count, no boundary: if step ≤ count, count -= step.
- Down boundary event: if step > count:
  - CNT_WRAP: count = count+(MAX_VAL+1)-step.
  - CNT_SATURATE: count = 0.
  - Both modes: tc=1, unf set.
- Exact landing on MAX_VAL (up) or 0 (down) is not a boundary event: tc=0.
- Saturate mode held at the limit: each further enabled step in the same direction re-asserts tc (continuous tc while pinned).
- Arithmetic: computed in WIDTH+1 bits, no truncation before comparison.
- Latency: count and tc change on the edge following the sampled inputs; all outputs except at_max/at_min are registered.
- Step constraint: step > MAX_VAL is illegal. A simulation assertion flags it; RTL behaviour is then don't-care but must keep count ≤ MAX_VAL.
- Invariant: count ≤ MAX_VAL in all cycles.

Decomposition:
- counter_pkg holds:
  - typedef enum logic {CNT_WRAP, CNT_SATURATE} cnt_mode_e.
  - localparam defaults for WIDTH and STEP_W.
- One combinational sub-module, count_next_calc (params WIDTH, MAX_VAL, STEP_W, MODE):
  - inputs: count, up_down, step.
  - outputs: next_count, boundary, dir_up.
- The top holds the registers, priority mux, tc/sticky flags and the assertion.

Test Plan:
All scenarios use WIDTH=4, MAX_VAL=9, STEP_W=4 unless noted.
1. Reset: rst=1 mid-cycle with count=6 -> count=0, tc=0, ovf=unf=0 immediately, before any clk edge; at_min=1.
2. Wrap up: load 7, enable=1, up, step=1, 3 edges -> count 8, 9, 0. tc=1 only in the cycle after 9→0; ovf=1 and stays set; at_max=1 while count=9.
3. Wrap down with step: load 1, down, step=3 -> count=8, tc=1, unf=1. Next edge -> count=5, tc=0.
4. Saturate (MODE=CNT_SATURATE): load 8, up, step=3 -> count=9, tc=1. Next edge -> count=9, tc=1. Then down, step=9 -> count=0, tc=0 (exact landing).
5. Load clamp and priority: d_in=12, load=1 -> count=9. Then clear=1 and load=1 with d_in=4 in the same cycle -> count=0, ovf=unf=0 (clear wins). Then load=1 with enable=1 -> count=d_in, no step applied.
6. Hold: enable=0 for 5 edges at count=5 -> count=5, tc=0. Enable=1 with step=0 -> count=5, tc=0.
7. Default-parameter instance: WIDTH=8, up from 250, step=10 -> count=4, tc=1.
